// File: rtl/magia_mesh_launch_ctrl.sv
// magia_mesh_launch_ctrl
// Launch and completion sequencer for the MAGIA mesh. It raises tile_enable,
// waits for the tiles to settle, then releases fetch_enable per masked tile in
// row-major index order with a fixed stagger. A tile counts as finished once its
// core_sleep has been stable high for SLEEP_STABLE cycles. The run ends with
// done when every masked tile has finished, or with timeout when the cycle
// budget runs out first.
module magia_mesh_launch_ctrl #(
   parameter int N_TILES_Y      = 2,
   parameter int N_TILES_X      = 2,
   parameter int SETTLE_CYCLES  = 8,
   parameter int STAGGER_CYCLES = 4,
   parameter int SLEEP_STABLE   = 16,
   parameter int CNT_W          = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   input  logic                           abort_i,
   input  logic [N_TILES_Y*N_TILES_X-1:0] tile_mask_i,
   input  logic [CNT_W-1:0]               timeout_i,
   input  logic [N_TILES_Y*N_TILES_X-1:0] core_sleep_i,
   output logic                           tile_enable_o,
   output logic [N_TILES_Y*N_TILES_X-1:0] fetch_enable_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           timeout_o,
   output logic [N_TILES_Y*N_TILES_X-1:0] finished_o,
   output logic [CNT_W-1:0]               cycles_o
);

   localparam int N_TILES = N_TILES_Y * N_TILES_X;
   localparam int IDX_W   = (N_TILES > 1) ? $clog2(N_TILES) : 1;
   localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
   localparam int STG_W   = $clog2(STAGGER_CYCLES + 1);
   localparam int RUN_W   = $clog2(SLEEP_STABLE + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENABLE  = 3'd1,
      LAUNCH  = 3'd2,
      RUN     = 3'd3,
      DONE    = 3'd4,
      TIMEOUT = 3'd5
   } state_t;

   state_t               state_reg, state_next;
   logic [N_TILES-1:0]   mask_reg;
   logic [CNT_W-1:0]     budget_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [SET_W-1:0]     settle_reg;
   logic [STG_W-1:0]     stag_reg;
   logic [IDX_W-1:0]     idx_reg;
   logic                 tile_en_reg;
   logic [N_TILES-1:0]   fetch_reg;
   logic                 done_reg;
   logic                 timeout_reg;
   logic [CNT_W-1:0]     cycles_reg;
   logic [N_TILES-1:0]   finished_w;

   logic idle_like;
   logic busy;
   logic accept;
   logic detect_en;
   logic timeout_hit;
   logic launch_step;
   logic last_idx;

   assign idle_like   = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == TIMEOUT);
   assign busy        = (state_reg == ENABLE) || (state_reg == LAUNCH) || (state_reg == RUN);
   assign accept      = start_i && idle_like && !abort_i;
   assign detect_en   = (state_reg == LAUNCH) || (state_reg == RUN);
   assign timeout_hit = (budget_reg != '0) && (cnt_reg == budget_reg);
   assign last_idx    = (idx_reg == IDX_W'(N_TILES - 1));
   // An unmasked index is skipped in one cycle; a masked one holds the full stagger.
   assign launch_step = (state_reg == LAUNCH) &&
                        (!mask_reg[idx_reg] || (stag_reg == STG_W'(STAGGER_CYCLES - 1)));

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; abort wins over everything, done wins over timeout.
   always_comb begin
      state_next = state_reg;
      if (abort_i) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE, DONE, TIMEOUT: if (start_i) state_next = ENABLE;
            ENABLE: begin
               if (timeout_hit)                                   state_next = TIMEOUT;
               else if (settle_reg == SET_W'(SETTLE_CYCLES - 1))  state_next = LAUNCH;
            end
            LAUNCH: begin
               if (timeout_hit)                   state_next = TIMEOUT;
               else if (launch_step && last_idx)  state_next = RUN;
            end
            RUN: begin
               if (finished_w == mask_reg)  state_next = DONE;
               else if (timeout_hit)        state_next = TIMEOUT;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Output decode.
   always_comb begin
      busy_o         = busy;
      tile_enable_o  = tile_en_reg;
      fetch_enable_o = fetch_reg;
      done_o         = done_reg;
      timeout_o      = timeout_reg;
      finished_o     = finished_w;
      cycles_o       = cycles_reg;
   end

   // Launch datapath: latch run parameters, count cycles, stagger fetch releases, latch result.
   always_ff @(posedge clk_i) begin
      if (rst_i || abort_i) begin
         mask_reg    <= '0;
         budget_reg  <= '0;
         cnt_reg     <= '0;
         settle_reg  <= '0;
         stag_reg    <= '0;
         idx_reg     <= '0;
         tile_en_reg <= 1'b0;
         fetch_reg   <= '0;
         done_reg    <= 1'b0;
         timeout_reg <= 1'b0;
         cycles_reg  <= '0;
      end else begin
         if (accept) begin
            mask_reg    <= tile_mask_i;
            budget_reg  <= timeout_i;
            cnt_reg     <= '0;
            settle_reg  <= '0;
            stag_reg    <= '0;
            idx_reg     <= '0;
            tile_en_reg <= 1'b1;
            fetch_reg   <= '0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
         end
         if (busy && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (state_reg == ENABLE) begin
            settle_reg <= settle_reg + 1'b1;
         end
         if (state_reg == LAUNCH) begin
            if (mask_reg[idx_reg] && (stag_reg == '0)) begin
               fetch_reg[idx_reg] <= 1'b1;
            end
            if (launch_step) begin
               stag_reg <= '0;
               if (!last_idx) idx_reg <= idx_reg + 1'b1;
            end else begin
               stag_reg <= stag_reg + 1'b1;
            end
         end
         // Terminal transitions override any fetch release issued this cycle.
         if (busy && (state_next == DONE)) begin
            done_reg   <= 1'b1;
            cycles_reg <= cnt_reg;
            fetch_reg  <= '0;
         end
         if (busy && (state_next == TIMEOUT)) begin
            timeout_reg <= 1'b1;
            cycles_reg  <= cnt_reg;
            fetch_reg   <= '0;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_TILES; gi++) begin : g_tile
         logic [RUN_W-1:0] run_reg;
         logic             fin_reg;

         // Per-tile sleep-stability counter; finished is sticky until the next launch.
         always_ff @(posedge clk_i) begin
            if (rst_i || abort_i || accept) begin
               run_reg <= '0;
               fin_reg <= 1'b0;
            end else if (detect_en) begin
               if (fetch_reg[gi] && core_sleep_i[gi]) begin
                  if (run_reg != RUN_W'(SLEEP_STABLE)) run_reg <= run_reg + 1'b1;
                  if (run_reg == RUN_W'(SLEEP_STABLE - 1)) fin_reg <= 1'b1;
               end else begin
                  run_reg <= '0;
               end
            end
         end

         assign finished_w[gi] = fin_reg;
      end
   endgenerate

endmodule

// File: tb/tb_magia_mesh_launch_ctrl.sv
// Self-checking bench for magia_mesh_launch_ctrl (2x2 mesh, default timing).
// Cycle numbers are edges counted from the edge that accepts start_i (edge 0).
module tb_magia_mesh_launch_ctrl;

   localparam int N  = 4;
   localparam int CW = 32;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [N-1:0]  tile_mask_i = '0;
   logic [CW-1:0] timeout_i = '0;
   logic [N-1:0]  core_sleep_i = '0;
   logic          tile_enable_o;
   logic [N-1:0]  fetch_enable_o;
   logic          busy_o;
   logic          done_o;
   logic          timeout_o;
   logic [N-1:0]  finished_o;
   logic [CW-1:0] cycles_o;

   magia_mesh_launch_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .tile_mask_i    (tile_mask_i),
      .timeout_i      (timeout_i),
      .core_sleep_i   (core_sleep_i),
      .tile_enable_o  (tile_enable_o),
      .fetch_enable_o (fetch_enable_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .timeout_o      (timeout_o),
      .finished_o     (finished_o),
      .cycles_o       (cycles_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit         is_to;
      int         cyc;
      logic [3:0] fin;
      int         end_edge;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   fe_age[N] = '{0, 0, 0, 0};
   int   gcyc = 0;
   bit   toggle1 = 1'b0;
   int   rise[N];
   int   end_cyc;
   int   cur;

   // Tile model: core_sleep goes high 50 cycles after fetch release; tile 1 can glitch low every 10 cycles.
   always @(posedge clk_i) begin
      #1;
      gcyc++;
      for (int t = 0; t < N; t++) begin
         if (fetch_enable_o[t] === 1'b1) fe_age[t]++;
         else                            fe_age[t] = 0;
         core_sleep_i[t] = (fe_age[t] > 50);
         if (toggle1 && t == 1 && (gcyc % 10) == 0) core_sleep_i[t] = 1'b0;
      end
   end

   task automatic start_run(input logic [3:0] mask, input int budget);
      @(posedge clk_i); #1;
      tile_mask_i = mask;
      timeout_i   = budget;
      start_i     = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cur     = 0;
      end_cyc = -1;
      for (int t = 0; t < N; t++) rise[t] = -1;
   endtask

   task automatic watch(input int limit, input int glitch_at, input logic [3:0] glitch_mask);
      for (int k = 0; k < limit; k++) begin
         @(posedge clk_i); #1;
         cur++;
         start_i = (cur == glitch_at);
         if (cur == glitch_at) tile_mask_i = glitch_mask;
         for (int t = 0; t < N; t++)
            if (fetch_enable_o[t] === 1'b1 && rise[t] < 0) rise[t] = cur;
         if (done_o === 1'b1 || timeout_o === 1'b1) begin
            end_cyc = cur;
            break;
         end
      end
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      n_checks++;
      if ({tile_enable_o, fetch_enable_o, busy_o, done_o, timeout_o, finished_o, cycles_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got te=%b fe=%b busy=%b done=%b to=%b fin=%b cyc=%0d, want all 0",
                  tile_enable_o, fetch_enable_o, busy_o, done_o, timeout_o, finished_o, cycles_o);
      end
      rst_i = 1'b0;
      $display("reset: outputs te=%b fe=%b busy=%b", tile_enable_o, fetch_enable_o, busy_o);
   endtask

   task automatic test_full_mask();
      int   exp_rise[N] = '{9, 13, 17, 21};
      exp_t e;
      sb.push_back('{is_to: 1'b0, cyc: 87, fin: 4'hF, end_edge: 88});
      start_run(4'hF, 0);
      n_checks++;
      if (busy_o !== 1'b1 || tile_enable_o !== 1'b1) begin
         n_fail++;
         $display("FAIL full_start: busy=%b te=%b, want 1 1", busy_o, tile_enable_o);
      end
      watch(300, -1, 4'h0);
      for (int t = 0; t < N; t++) begin
         n_checks++;
         if (rise[t] !== exp_rise[t]) begin
            n_fail++;
            $display("FAIL full_rise%0d: got %0d, want %0d", t, rise[t], exp_rise[t]);
         end
      end
      e = sb.pop_front();
      n_checks++;
      if (end_cyc !== e.end_edge || done_o !== 1'b1 || timeout_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_end: edge=%0d done=%b to=%b, want edge=%0d done=1 to=0", end_cyc, done_o, timeout_o, e.end_edge);
      end
      n_checks++;
      if (cycles_o !== e.cyc || finished_o !== e.fin) begin
         n_fail++;
         $display("FAIL full_result: cycles=%0d fin=%b, want cycles=%0d fin=%b", cycles_o, finished_o, e.cyc, e.fin);
      end
      n_checks++;
      if (fetch_enable_o !== 4'h0 || tile_enable_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_done_outs: fe=%b te=%b busy=%b, want 0000 1 0", fetch_enable_o, tile_enable_o, busy_o);
      end
      $display("full_mask: rises %0d %0d %0d %0d end=%0d cycles=%0d fin=%b",
               rise[0], rise[1], rise[2], rise[3], end_cyc, cycles_o, finished_o);
   endtask

   task automatic test_partial_mask();
      int   exp_rise[N] = '{9, -1, 14, -1};
      exp_t e;
      sb.push_back('{is_to: 1'b0, cyc: 80, fin: 4'b0101, end_edge: 81});
      start_run(4'b0101, 0);
      watch(300, -1, 4'h0);
      for (int t = 0; t < N; t++) begin
         n_checks++;
         if (rise[t] !== exp_rise[t]) begin
            n_fail++;
            $display("FAIL part_rise%0d: got %0d, want %0d", t, rise[t], exp_rise[t]);
         end
      end
      e = sb.pop_front();
      n_checks++;
      if (end_cyc !== e.end_edge || done_o !== 1'b1 || cycles_o !== e.cyc || finished_o !== e.fin) begin
         n_fail++;
         $display("FAIL part_end: edge=%0d done=%b cycles=%0d fin=%b, want edge=%0d done=1 cycles=%0d fin=%b",
                  end_cyc, done_o, cycles_o, finished_o, e.end_edge, e.cyc, e.fin);
      end
      $display("partial_mask: rises %0d %0d %0d %0d end=%0d cycles=%0d fin=%b",
               rise[0], rise[1], rise[2], rise[3], end_cyc, cycles_o, finished_o);
   endtask

   task automatic test_timeout();
      exp_t e;
      toggle1 = 1'b1;
      sb.push_back('{is_to: 1'b1, cyc: 200, fin: 4'b1101, end_edge: 201});
      start_run(4'hF, 200);
      watch(400, -1, 4'h0);
      e = sb.pop_front();
      n_checks++;
      if (end_cyc !== e.end_edge || timeout_o !== 1'b1 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL to_end: edge=%0d to=%b done=%b, want edge=%0d to=1 done=0", end_cyc, timeout_o, done_o, e.end_edge);
      end
      n_checks++;
      if (cycles_o !== e.cyc || finished_o !== e.fin || fetch_enable_o !== 4'h0) begin
         n_fail++;
         $display("FAIL to_result: cycles=%0d fin=%b fe=%b, want cycles=%0d fin=%b fe=0000",
                  cycles_o, finished_o, fetch_enable_o, e.cyc, e.fin);
      end
      toggle1 = 1'b0;
      $display("timeout: end=%0d to=%b done=%b cycles=%0d fin=%b", end_cyc, timeout_o, done_o, cycles_o, finished_o);
   endtask

   task automatic test_empty_mask();
      exp_t e;
      sb.push_back('{is_to: 1'b0, cyc: 12, fin: 4'h0, end_edge: 13});
      start_run(4'h0, 0);
      watch(100, -1, 4'h0);
      e = sb.pop_front();
      n_checks++;
      if (end_cyc !== e.end_edge || done_o !== 1'b1 || cycles_o !== e.cyc || finished_o !== e.fin) begin
         n_fail++;
         $display("FAIL empty_end: edge=%0d done=%b cycles=%0d fin=%b, want edge=%0d done=1 cycles=%0d fin=%b",
                  end_cyc, done_o, cycles_o, finished_o, e.end_edge, e.cyc, e.fin);
      end
      n_checks++;
      if (rise[0] != -1 || rise[1] != -1 || rise[2] != -1 || rise[3] != -1) begin
         n_fail++;
         $display("FAIL empty_fetch: rises %0d %0d %0d %0d, want none", rise[0], rise[1], rise[2], rise[3]);
      end
      $display("empty_mask: end=%0d cycles=%0d", end_cyc, cycles_o);
   endtask

   task automatic test_start_ignored();
      int   exp_rise[N] = '{9, 13, 17, 21};
      exp_t e;
      sb.push_back('{is_to: 1'b0, cyc: 87, fin: 4'hF, end_edge: 88});
      start_run(4'hF, 0);
      watch(300, 11, 4'b0001);
      for (int t = 0; t < N; t++) begin
         n_checks++;
         if (rise[t] !== exp_rise[t]) begin
            n_fail++;
            $display("FAIL ign_rise%0d: got %0d, want %0d", t, rise[t], exp_rise[t]);
         end
      end
      e = sb.pop_front();
      n_checks++;
      if (end_cyc !== e.end_edge || cycles_o !== e.cyc || finished_o !== e.fin) begin
         n_fail++;
         $display("FAIL ign_end: edge=%0d cycles=%0d fin=%b, want edge=%0d cycles=%0d fin=%b",
                  end_cyc, cycles_o, finished_o, e.end_edge, e.cyc, e.fin);
      end
      $display("start_ignored: end=%0d cycles=%0d fin=%b", end_cyc, cycles_o, finished_o);
   endtask

   task automatic test_abort();
      exp_t e;
      start_run(4'hF, 0);
      watch(40, -1, 4'h0);
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      n_checks++;
      if (tile_enable_o !== 1'b0 || fetch_enable_o !== 4'h0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_outs: te=%b fe=%b busy=%b done=%b, want all 0", tile_enable_o, fetch_enable_o, busy_o, done_o);
      end
      sb.push_back('{is_to: 1'b0, cyc: 87, fin: 4'hF, end_edge: 88});
      start_run(4'hF, 0);
      n_checks++;
      if (finished_o !== 4'h0 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_restart: fin=%b busy=%b, want 0000 1", finished_o, busy_o);
      end
      watch(300, -1, 4'h0);
      e = sb.pop_front();
      n_checks++;
      if (end_cyc !== e.end_edge || cycles_o !== e.cyc || finished_o !== e.fin) begin
         n_fail++;
         $display("FAIL abort_rerun: edge=%0d cycles=%0d fin=%b, want edge=%0d cycles=%0d fin=%b",
                  end_cyc, cycles_o, finished_o, e.end_edge, e.cyc, e.fin);
      end
      $display("abort: relaunch end=%0d cycles=%0d fin=%b", end_cyc, cycles_o, finished_o);
   endtask

   task automatic test_reset_mid_run();
      start_run(4'hF, 0);
      watch(40, -1, 4'h0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      n_checks++;
      if ({tile_enable_o, fetch_enable_o, busy_o, done_o, timeout_o, finished_o, cycles_o} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid: te=%b fe=%b busy=%b done=%b to=%b fin=%b cyc=%0d, want all 0",
                  tile_enable_o, fetch_enable_o, busy_o, done_o, timeout_o, finished_o, cycles_o);
      end
      $display("reset_mid_run: te=%b fe=%b busy=%b", tile_enable_o, fetch_enable_o, busy_o);
   endtask

   initial begin
      test_reset();
      test_full_mask();
      test_partial_mask();
      test_timeout();
      test_empty_mask();
      test_start_ignored();
      test_abort();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
